// File: rtl/multicycle_control_pkg.sv
// rv_ctrl_pkg: definitions shared by the multi-cycle RISC-V control unit.
//   state_e  - FSM state encoding. TRAP exists only when
//              MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN is defined.
//   OPC_*    - 7-bit RV32I major opcodes that the controller decodes.
//   WB_*     - write-back source select codes driven on wb_sel.
package rv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB,
    S_BRANCH,
    S_JUMP
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_e;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_IMM = 2'b11;

endpackage

// File: rtl/multicycle_control_if.sv
// multicycle_control_if: instruction/data memory handshake bundle.
//   imem_req/imem_ready - instruction fetch request and data-valid response.
//   dmem_req/dmem_ready - data access request and completion response.
//   mem_read/mem_write  - direction qualifiers for dmem_req.
// Modports: master = controller side, slave = memory side.
interface multicycle_control_if;
  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_ready;
  logic mem_read;
  logic mem_write;

  modport master (
    output imem_req, dmem_req, mem_read, mem_write,
    input  imem_ready, dmem_ready
  );

  modport slave (
    input  imem_req, dmem_req, mem_read, mem_write,
    output imem_ready, dmem_ready
  );
endinterface

// File: rtl/multicycle_control_wait_timer.sv
// mc_wait_timer: counts consecutive cycles spent waiting for a memory ready.
//   clk, rst_n - clock, asynchronous active-low reset.
//   active     - controller is in a state that waits on a ready.
//   ready      - the ready that belongs to the current waiting state.
//   expire     - WAIT_MAX cycles already elapsed and ready still low
//                (ready in the same cycle wins).
// The count clears whenever the controller leaves the waiting state, which
// only happens on ready or on expiry.
module mc_wait_timer #(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic ready,
  output logic expire
);

  localparam int unsigned CW = $clog2(WAIT_MAX + 1);

  if (WAIT_MAX < 1) begin : g_wait_max_chk
    $error("mc_wait_timer: WAIT_MAX must be at least 1");
  end

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    expire = active && !ready && (cnt_q == CW'(WAIT_MAX));
    if (!active || ready || expire) cnt_d = '0;
    else                            cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle RISC-V control FSM
// (FETCH/DECODE/EXEC/MEM_ADDR/MEM_RD/MEM_WR/WB/BRANCH/JUMP).
//   clk, rst_n   - clock, asynchronous active-low reset.
//   opcode       - opcode field of the instruction register (held after fetch).
//   mem          - memory handshake bundle (imem_req/ready, dmem_req/ready,
//                  mem_read, mem_write).
//   ir_write, pc_inc            - fetch complete (FETCH and imem_ready).
//   pc_branch, pc_jump          - BEQ / JAL PC update.
//   reg_write, alu_src, wb_sel  - datapath controls.
//   mem_timeout  - one-cycle pulse when a memory wait is abandoned.
//   instret      - retired-instruction counter (wraps).
//   illegal_instr - only with MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN: an unknown
//                  opcode parks the controller in TRAP until reset.
module multicycle_control
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned OPC_W    = 7,
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [OPC_W-1:0]     opcode,
  multicycle_control_if.master mem,
  output logic                 ir_write,
  output logic                 pc_inc,
  output logic                 pc_branch,
  output logic                 pc_jump,
  output logic                 reg_write,
  output logic                 alu_src,
  output logic [1:0]           wb_sel,
  output logic                 mem_timeout,
  output logic [CNT_W-1:0]     instret
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
  ,
  output logic                 illegal_instr
`endif
);

  if (OPC_W != 7) begin : g_opc_w_chk
    $error("multicycle_control: OPC_W must be 7");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [6:0]       opc;
  logic             waiting, ready_sel, expire, retire;

  assign opc       = opcode;
  assign waiting   = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign ready_sel = (state_q == S_FETCH) ? mem.imem_ready : mem.dmem_ready;

  mc_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .active (waiting),
    .ready  (ready_sel),
    .expire (expire)
  );

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH:    if (mem.imem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opc)
          OPC_RTYPE, OPC_ITYPE, OPC_LUI: state_d = S_EXEC;
          OPC_LOAD, OPC_STORE:           state_d = S_MEM_ADDR;
          OPC_BRANCH:                    state_d = S_BRANCH;
          OPC_JAL:                       state_d = S_JUMP;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
          default:                       state_d = S_TRAP;
`else
          default:                       state_d = S_FETCH;
`endif
        endcase
      end
      S_EXEC:     state_d = S_WB;
      S_MEM_ADDR: state_d = (opc == OPC_STORE) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD: begin
        if (mem.dmem_ready) state_d = S_WB;
        else if (expire)    state_d = S_FETCH;
      end
      S_MEM_WR: begin
        if (mem.dmem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else if (expire) begin
          state_d = S_FETCH;
        end
      end
      S_WB, S_BRANCH, S_JUMP: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
      S_TRAP:     state_d = S_TRAP;
`endif
      default:    state_d = S_FETCH;
    endcase
    instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Reset parks the state in FETCH, so the fetch-side outputs are also gated
  // by rst_n to keep every output low while reset is held.
  always_comb begin
    mem.imem_req  = 1'b0;
    mem.dmem_req  = 1'b0;
    mem.mem_read  = 1'b0;
    mem.mem_write = 1'b0;
    ir_write      = 1'b0;
    pc_inc        = 1'b0;
    pc_branch     = 1'b0;
    pc_jump       = 1'b0;
    reg_write     = 1'b0;
    alu_src       = 1'b0;
    wb_sel        = WB_ALU;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    illegal_instr = 1'b0;
`endif
    case (state_q)
      S_FETCH: begin
        mem.imem_req = rst_n;
        ir_write     = rst_n && mem.imem_ready;
        pc_inc       = rst_n && mem.imem_ready;
      end
      S_EXEC:     alu_src = (opc == OPC_ITYPE);
      S_MEM_ADDR: alu_src = 1'b1;
      S_MEM_RD: begin
        mem.dmem_req = 1'b1;
        mem.mem_read = 1'b1;
        alu_src      = 1'b1;
      end
      S_MEM_WR: begin
        mem.dmem_req  = 1'b1;
        mem.mem_write = 1'b1;
        alu_src       = 1'b1;
      end
      S_WB: begin
        reg_write = 1'b1;
        if (opc == OPC_LUI)       wb_sel = WB_IMM;
        else if (opc == OPC_LOAD) wb_sel = WB_MEM;
        else                      wb_sel = WB_ALU;
      end
      S_BRANCH:   pc_branch = 1'b1;
      S_JUMP: begin
        pc_jump   = 1'b1;
        reg_write = 1'b1;
        wb_sel    = WB_PC4;
      end
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
      S_TRAP:     illegal_instr = 1'b1;
`endif
      default: ;
    endcase
  end

  assign mem_timeout = expire;
  assign instret     = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each instruction is expanded
// into an expected per-cycle output trace from the sequencing rules
// (fetch wait, decode, class-specific cycles, memory waits and timeouts),
// then replayed against the DUT while driving the ready inputs.
module tb_multicycle_control;

  localparam int unsigned WAIT_MAX = 15;
  localparam int unsigned CNT_W    = 32;

  // Output vector bit positions:
  // {imem_req,dmem_req,mem_read,mem_write,ir_write,pc_inc,pc_branch,pc_jump,
  //  reg_write,alu_src,wb_sel[1:0],mem_timeout}
  localparam logic [12:0] IREQ = 13'h1000;
  localparam logic [12:0] DREQ = 13'h0800;
  localparam logic [12:0] MRD  = 13'h0400;
  localparam logic [12:0] MWR  = 13'h0200;
  localparam logic [12:0] IRW  = 13'h0100;
  localparam logic [12:0] PCI  = 13'h0080;
  localparam logic [12:0] PBR  = 13'h0040;
  localparam logic [12:0] PJ   = 13'h0020;
  localparam logic [12:0] RW   = 13'h0010;
  localparam logic [12:0] AS   = 13'h0008;
  localparam logic [12:0] WMEM = 13'h0002;
  localparam logic [12:0] WPC4 = 13'h0004;
  localparam logic [12:0] WIMM = 13'h0006;
  localparam logic [12:0] TO   = 13'h0001;

  localparam logic [6:0] R_OP  = 7'b0110011;
  localparam logic [6:0] I_OP  = 7'b0010011;
  localparam logic [6:0] LW_OP = 7'b0000011;
  localparam logic [6:0] SW_OP = 7'b0100011;
  localparam logic [6:0] BQ_OP = 7'b1100011;
  localparam logic [6:0] JL_OP = 7'b1101111;
  localparam logic [6:0] LU_OP = 7'b0110111;
  localparam logic [6:0] BAD   = 7'b1111111;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [6:0]       opcode;
  logic             ir_write, pc_inc, pc_branch, pc_jump, reg_write, alu_src, mem_timeout;
  logic [1:0]       wb_sel;
  logic [CNT_W-1:0] instret;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
  logic             illegal_instr;
`endif

  multicycle_control_if mif ();

  multicycle_control #(.OPC_W(7), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .mem         (mif),
    .ir_write    (ir_write),
    .pc_inc      (pc_inc),
    .pc_branch   (pc_branch),
    .pc_jump     (pc_jump),
    .reg_write   (reg_write),
    .alu_src     (alu_src),
    .wb_sel      (wb_sel),
    .mem_timeout (mem_timeout),
    .instret     (instret)
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    ,
    .illegal_instr (illegal_instr)
`endif
  );

  always #5 clk = ~clk;

  logic [12:0] outv;
  assign outv = {mif.imem_req, mif.dmem_req, mif.mem_read, mif.mem_write, ir_write, pc_inc,
                 pc_branch, pc_jump, reg_write, alu_src, wb_sel, mem_timeout};

  int unsigned      vectors    = 0;
  int unsigned      miscompares = 0;
  logic [CNT_W-1:0] exp_instret = '0;
  logic [12:0]      exp_q[$];
  logic [1:0]       rdy_q[$];   // {imem_ready, dmem_ready}

  function automatic logic rb();
    return 1'($urandom_range(1));
  endfunction

  // Fetch phase; latencies beyond WAIT_MAX expand into abort-and-refetch rounds.
  task automatic plan_fetch(input int unsigned lat);
    int unsigned l = lat;
    while (l > WAIT_MAX) begin
      for (int unsigned i = 0; i < WAIT_MAX; i++) begin
        exp_q.push_back(IREQ); rdy_q.push_back({1'b0, rb()});
      end
      exp_q.push_back(IREQ | TO); rdy_q.push_back({1'b0, rb()});
      l -= WAIT_MAX + 1;
    end
    for (int unsigned i = 0; i < l; i++) begin
      exp_q.push_back(IREQ); rdy_q.push_back({1'b0, rb()});
    end
    exp_q.push_back(IREQ | IRW | PCI); rdy_q.push_back({1'b1, rb()});
  endtask

  // Data-memory wait; returns 1 when the access completes, 0 on abort.
  task automatic plan_mem(input logic [12:0] v, input int unsigned lat, output logic done);
    if (lat > WAIT_MAX) begin
      for (int unsigned i = 0; i < WAIT_MAX; i++) begin
        exp_q.push_back(v); rdy_q.push_back({rb(), 1'b0});
      end
      exp_q.push_back(v | TO); rdy_q.push_back({rb(), 1'b0});
      done = 1'b0;
    end else begin
      for (int unsigned i = 0; i < lat; i++) begin
        exp_q.push_back(v); rdy_q.push_back({rb(), 1'b0});
      end
      exp_q.push_back(v); rdy_q.push_back({rb(), 1'b1});
      done = 1'b1;
    end
  endtask

  task automatic plan_instr(input logic [6:0] opc, input int unsigned flat, input int unsigned mlat);
    logic done;
    plan_fetch(flat);
    exp_q.push_back('0); rdy_q.push_back({rb(), rb()});   // decode
    case (opc)
      R_OP, I_OP, LU_OP: begin
        exp_q.push_back(opc == I_OP ? AS : 13'h0); rdy_q.push_back({rb(), rb()});
        exp_q.push_back(RW | (opc == LU_OP ? WIMM : 13'h0)); rdy_q.push_back({rb(), rb()});
        exp_instret++;
      end
      LW_OP: begin
        exp_q.push_back(AS); rdy_q.push_back({rb(), rb()});
        plan_mem(DREQ | MRD | AS, mlat, done);
        if (done) begin
          exp_q.push_back(RW | WMEM); rdy_q.push_back({rb(), rb()});
          exp_instret++;
        end
      end
      SW_OP: begin
        exp_q.push_back(AS); rdy_q.push_back({rb(), rb()});
        plan_mem(DREQ | MWR | AS, mlat, done);
        if (done) exp_instret++;
      end
      BQ_OP: begin
        exp_q.push_back(PBR); rdy_q.push_back({rb(), rb()});
        exp_instret++;
      end
      JL_OP: begin
        exp_q.push_back(PJ | RW | WPC4); rdy_q.push_back({rb(), rb()});
        exp_instret++;
      end
      default: ;
    endcase
  endtask

  // Replays the planned trace; entered and left just after a rising edge.
  task automatic play(input string name);
    logic [1:0]  r;
    logic [12:0] e;
    int unsigned cyc = 0;
    while (exp_q.size() > 0) begin
      r = rdy_q.pop_front();
      e = exp_q.pop_front();
      mif.imem_ready = r[1];
      mif.dmem_ready = r[0];
      @(negedge clk);
      vectors++;
      if (outv !== e) begin
        miscompares++;
        $display("FAIL %s cycle %0d outputs: got %h expected %h", name, cyc, outv, e);
      end
      cyc++;
      @(posedge clk); #1;
    end
    mif.imem_ready = 1'b0;
    mif.dmem_ready = 1'b0;
  endtask

  task automatic check_instret(input string name);
    vectors++;
    if (instret !== exp_instret) begin
      miscompares++;
      $display("FAIL %s instret: got %0d expected %0d", name, instret, exp_instret);
    end
  endtask

  task automatic run(input string name, input logic [6:0] opc, input int unsigned flat,
                     input int unsigned mlat);
    opcode = opc;
    plan_instr(opc, flat, mlat);
    play(name);
    check_instret(name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; opcode = '0; mif.imem_ready = 1'b0; mif.dmem_ready = 1'b0;
    #1;
    vectors++;
    if (outv !== 13'h0 || instret !== '0) begin
      miscompares++;
      $display("FAIL reset_hold: got outv %h instret %0d expected 0 0", outv, instret);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); #1 rst_n = 1'b1;
    #1;
    vectors++;
    if (outv !== IREQ) begin
      miscompares++;
      $display("FAIL reset_release: got %h expected %h", outv, IREQ);
    end
    exp_instret = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_addi();      run("addi", I_OP, 2, 0);            endtask
  task automatic test_lui_rtype(); run("lui", LU_OP, 0, 0); run("rtype", R_OP, 1, 0); endtask
  task automatic test_load();      run("load", LW_OP, 1, 3);           endtask
  task automatic test_store_timeout(); run("store_timeout", SW_OP, 0, WAIT_MAX + 1); endtask
  task automatic test_load_timeout();  run("load_timeout", LW_OP, 0, WAIT_MAX + 5); endtask
  task automatic test_ready_at_limit();
    run("store_at_limit", SW_OP, WAIT_MAX, WAIT_MAX);
    run("load_at_limit", LW_OP, 0, WAIT_MAX);
  endtask
  task automatic test_fetch_timeout(); run("fetch_timeout", I_OP, WAIT_MAX + 3, 0); endtask
  task automatic test_back_to_back();
    run("beq", BQ_OP, 0, 0);
    run("jal", JL_OP, 0, 0);
  endtask

  task automatic test_illegal();
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    opcode = BAD;
    plan_instr(BAD, 1, 0);
    play("illegal_enter");
    for (int i = 0; i < 20; i++) begin
      mif.imem_ready = rb(); mif.dmem_ready = rb();
      @(negedge clk);
      vectors++;
      if (illegal_instr !== 1'b1 || outv !== 13'h0) begin
        miscompares++;
        $display("FAIL trap_hold cycle %0d: got illegal %b outv %h expected 1 0", i, illegal_instr, outv);
      end
      @(posedge clk); #1;
    end
    check_instret("trap");
    test_reset();
`else
    run("illegal_nop", BAD, 1, 0);
`endif
  endtask

  task automatic test_reset_mid();
    opcode = LW_OP;
    plan_fetch(0);
    exp_q.push_back('0); rdy_q.push_back(2'b00);
    exp_q.push_back(AS); rdy_q.push_back(2'b00);
    play("reset_mid_lead");
    @(negedge clk);
    vectors++;
    if (outv !== (DREQ | MRD | AS)) begin
      miscompares++;
      $display("FAIL reset_mid_in_memrd: got %h expected %h", outv, DREQ | MRD | AS);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (outv !== 13'h0 || instret !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_async: got outv %h instret %0d expected 0 0", outv, instret);
    end
    @(negedge clk); #1 rst_n = 1'b1;
    exp_instret = '0;
    #1;
    vectors++;
    if (outv !== IREQ || instret !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_release: got outv %h instret %0d expected %h 0", outv, instret, IREQ);
    end
    @(posedge clk); #1;
    run("after_reset", I_OP, 0, 0);
  endtask

  task automatic test_random();
    logic [6:0] ops [8];
    int unsigned n_ops;
    ops = '{R_OP, I_OP, LW_OP, SW_OP, BQ_OP, JL_OP, LU_OP, BAD};
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
    n_ops = 7;
`else
    n_ops = 8;
`endif
    for (int i = 0; i < 60; i++) begin
      logic [6:0] o;
      int unsigned fl, ml;
      o  = ops[$urandom_range(n_ops - 1)];
      fl = ($urandom_range(9) == 0) ? $urandom_range(WAIT_MAX + 6, WAIT_MAX + 1) : $urandom_range(4);
      case ($urandom_range(5))
        0:       ml = WAIT_MAX;
        1:       ml = WAIT_MAX + 1;
        default: ml = $urandom_range(5);
      endcase
      run("random", o, fl, ml);
    end
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_addi();
        test_lui_rtype();
        test_load();
        test_store_timeout();
        test_load_timeout();
        test_ready_at_limit();
        test_fetch_timeout();
        test_back_to_back();
        test_illegal();
        test_reset_mid();
        test_random();
      end
      begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit");
        miscompares++;
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
